// File: rtl/anubis_round_key_ctrl.sv
// Anubis round-key sequencer: drives key_evolution/key_selection controls and issues K0..K(NUM_ROUNDS) one per handshake.
// Latency: first key valid 1+KS_CYCLES cycles after start, later keys EVOLVE_CYCLES+KS_CYCLES after each accept; rk_valid holds until rk_ready.
module anubis_round_key_ctrl #(
  parameter int NUM_ROUNDS    = 12,
  parameter int KS_CYCLES     = 4,
  parameter int EVOLVE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  output logic       ke_load,
  output logic       ke_step,
  output logic [3:0] ke_const_idx,
  output logic       ks_load,
  output logic [3:0] ks_counter,
  output logic       rk_valid,
  input  logic       rk_ready,
  output logic [3:0] rk_index,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, LOAD, SELECT, PRESENT, EVOLVE, DONE} state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [3:0] KS_LAST    = 4'(KS_CYCLES - 1);
  localparam logic [3:0] EV_LAST    = 4'(EVOLVE_CYCLES - 1);

  state_t     state;
  logic [3:0] r;
  logic [3:0] ev_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      r            <= '0;
      ev_cnt       <= '0;
      ke_load      <= 1'b0;
      ke_step      <= 1'b0;
      ke_const_idx <= '0;
      ks_load      <= 1'b0;
      ks_counter   <= '0;
      rk_valid     <= 1'b0;
      rk_index     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      ke_load <= 1'b0;
      ke_step <= 1'b0;
      ks_load <= 1'b0;
      done    <= 1'b0;
      // abort wins over start, accept and every counter transition
      if (abort && state != IDLE) begin
        state        <= IDLE;
        r            <= '0;
        ev_cnt       <= '0;
        ke_const_idx <= '0;
        ks_counter   <= '0;
        rk_valid     <= 1'b0;
        rk_index     <= '0;
        busy         <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              state   <= LOAD;
              ke_load <= 1'b1;
              busy    <= 1'b1;
              r       <= '0;
            end
          end
          LOAD: begin
            state      <= SELECT;
            ks_load    <= 1'b1;
            ks_counter <= '0;
          end
          SELECT: begin
            if (ks_counter == KS_LAST) begin
              state    <= PRESENT;
              rk_valid <= 1'b1;
              rk_index <= r;
            end else begin
              ks_counter <= ks_counter + 4'd1;
            end
          end
          PRESENT: begin
            if (rk_ready) begin
              rk_valid <= 1'b0;
              if (r == LAST_ROUND) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state        <= EVOLVE;
                ke_step      <= 1'b1;
                ke_const_idx <= r + 4'd1;
                ev_cnt       <= '0;
              end
            end
          end
          EVOLVE: begin
            if (ev_cnt == EV_LAST) begin
              state      <= SELECT;
              r          <= r + 4'd1;
              ks_load    <= 1'b1;
              ks_counter <= '0;
            end else begin
              ev_cnt <= ev_cnt + 4'd1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
            r     <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
